// File: rtl/rr_arb8_enc_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arb8_enc_ctrl
//   Round-robin arbiter and grant sequencer for 8 requesters sharing one
//   downstream resource. Produces a registered one-hot grant together with
//   its binary index, so the index can drive a mux select directly.
//   The owner keeps the grant while its request stays high. When it drops
//   the request, the grant moves in the same edge to the next pending client,
//   scanning upward from the old owner.
//
//   Optional feature (compile-time macro ARB_TIMEOUT_EN):
//     When defined, an owner that has held the grant for MAX_HOLD
//     consecutive cycles while others wait is preempted. The grant moves to
//     the next pending client and preempt pulses for one cycle.
//     When undefined, no hold counter is built and preempt is tied low.
//
// Parameters
//   PTR_INIT : priority pointer after reset; highest-priority index for the
//              first arbitration
//   MAX_HOLD : max consecutive grant cycles per owner (2..256), only used
//              with ARB_TIMEOUT_EN
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous reset, active-high
//   req      in   8  request per client, bit i = client i
//   gnt      out  8  one-hot grant, registered, zero when idle
//   gnt_idx  out  3  binary index of the set gnt bit, 0 when idle
//   gnt_vld  out  1  high when any grant is active
//   preempt  out  1  one-cycle pulse when a grant was revoked by timeout
// ---------------------------------------------------------------------------
module rr_arb8_enc_ctrl #(
  parameter logic [2:0] PTR_INIT = 3'd0,
  parameter int         MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arb8_enc_ctrl: MAX_HOLD must be in 2..256");
  end

  logic [0:0] r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_vld;
  logic       r_preempt;

  logic [7:0] w_cand;
  logic [7:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_sel;
  logic       w_hit;
  logic       w_owner_req;
  logic       w_tmo;
  logic       w_load;
  logic       w_to_idle;
  logic       w_pre_fire;

  // Candidates always exclude the current owner. In IDLE r_gnt is zero, so
  // this is simply req. In GRANT it gives the "other requesters" set used by
  // both release and timeout rearbitration.
  assign w_cand      = req & ~r_gnt;
  assign w_owner_req = |(req & r_gnt);

  // Rotate so that bit 0 is the client at r_ptr, then take the lowest set
  // bit. r_ptr is loaded with owner+1 on every grant, so in GRANT it already
  // equals the required rescan start point o+1.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_rot = '0;
    w_off = '0;
    for (int i = 0; i < 8; i++) begin
      w_rot[i] = w_cand[3'(r_ptr + 3'(i))];
    end
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign w_hit = |w_cand;
  assign w_sel = r_ptr + w_off;

`ifdef ARB_TIMEOUT_EN
  localparam int         HW        = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] r_hold_cnt;

  assign w_tmo = (r_hold_cnt == HOLD_LAST);

  // Counts cycles in which the owner kept its request. It wraps to zero at
  // the limit even if nobody else is waiting, so the owner gets a fresh
  // window rather than being preempted later by a late arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (w_load) begin
      r_hold_cnt <= '0;
    end else if (r_state == S_GRANT && w_owner_req) begin
      r_hold_cnt <= w_tmo ? '0 : r_hold_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Decide what happens at the next edge.
  always_comb begin
    w_load     = 1'b0;
    w_to_idle  = 1'b0;
    w_pre_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = w_hit;
      end
      S_GRANT: begin
        if (!w_owner_req) begin
          w_load    = w_hit;
          w_to_idle = !w_hit;
        end else if (w_tmo && w_hit) begin
          w_load     = 1'b1;
          w_pre_fire = 1'b1;
        end
      end
      default: begin
        w_to_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= PTR_INIT;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_gnt_vld <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_pre_fire;
      if (w_load) begin
        r_state   <= S_GRANT;
        r_gnt     <= 8'(1) << w_sel;
        r_gnt_idx <= w_sel;
        r_gnt_vld <= 1'b1;
        r_ptr     <= w_sel + 3'd1;
      end else if (w_to_idle) begin
        r_state   <= S_IDLE;
        r_gnt     <= '0;
        r_gnt_idx <= '0;
        r_gnt_vld <= 1'b0;
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arb8_enc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_arb8_enc_ctrl
//   Self-checking bench for rr_arb8_enc_ctrl (PTR_INIT=0, MAX_HOLD=4).
//   Every driven cycle advances a behavioural reference model and pushes the
//   expected registered outputs to a queue; after the clock edge the entry is
//   popped and compared. Directed scenarios add explicit constant checks.
//   Works with or without ARB_TIMEOUT_EN defined.
// ---------------------------------------------------------------------------
module tb_rr_arb8_enc_ctrl;

  localparam logic [2:0] PTR_INIT = 3'd0;
  localparam int         MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  rr_arb8_enc_ctrl #(.PTR_INIT(PTR_INIT), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       pre;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_gnt = '0;
  int         m_idx = 0;
  logic       m_vld = 1'b0;
  logic       m_pre = 1'b0;
  int         m_ptr = int'(PTR_INIT);
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [7:0] r, input int base);
    for (int i = 0; i < 8; i++) begin
      if (r[(base + i) % 8]) return (base + i) % 8;
    end
    return -1;
  endfunction

  task automatic give(input int s);
    m_gnt = '0;
    m_gnt[s] = 1'b1;
    m_idx = s;
    m_vld = 1'b1;
    m_ptr = (s + 1) % 8;
    m_cnt = 0;
  endtask

  task automatic go_idle();
    m_gnt = '0;
    m_idx = 0;
    m_vld = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic rs);
    int s;
    logic [7:0] others;
    exp_t e;
    m_pre = 1'b0;
    if (rs) begin
      go_idle();
      m_ptr = int'(PTR_INIT);
      m_cnt = 0;
    end else if (!m_vld) begin
      s = first_from(r, m_ptr);
      if (s >= 0) give(s);
    end else if (r[m_idx]) begin
      if (TMO_EN) begin
        if (m_cnt == MAX_HOLD - 1) begin
          m_cnt = 0;
          others = r;
          others[m_idx] = 1'b0;
          s = first_from(others, (m_idx + 1) % 8);
          if (s >= 0) begin
            give(s);
            m_pre = 1'b1;
          end
        end else begin
          m_cnt++;
        end
      end
    end else begin
      s = first_from(r, (m_idx + 1) % 8);
      if (s >= 0) give(s);
      else go_idle();
    end
    e.gnt = m_gnt;
    e.idx = 3'(m_idx);
    e.vld = m_vld;
    e.pre = m_pre;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic [7:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(r, rs);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("sb_gnt", 32'(gnt), 32'(e.gnt));
      check("sb_idx", 32'(gnt_idx), 32'(e.idx));
      check("sb_vld", 32'(gnt_vld), 32'(e.vld));
      check("sb_pre", 32'(preempt), 32'(e.pre));
    end
  endtask

  initial begin
    logic [7:0] r;
    int exp_i;

    // Reset state
    step(8'hFF, 1'b1);
    step(8'h00, 1'b1);
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_pre", 32'(preempt), 32'd0);

    // T1: single request, 1-cycle latency, hold
    step(8'h00, 1'b0);
    check("t1_idle_vld", 32'(gnt_vld), 32'd0);
    step(8'h04, 1'b0);
    check("t1_gnt", 32'(gnt), 32'h04);
    check("t1_idx", 32'(gnt_idx), 32'd2);
    check("t1_vld", 32'(gnt_vld), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(8'h04, 1'b0);
      check("t1_hold", 32'(gnt), 32'h04);
    end
    step(8'h00, 1'b0);
    check("t1_release", 32'(gnt), 32'h00);

    // T2: full rotation with no idle gap
    step(8'h00, 1'b1);
    step(8'hFF, 1'b0);
    check("t2_first", 32'(gnt_idx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      r = 8'hFF;
      r[k] = 1'b0;
      step(r, 1'b0);
      exp_i = (k + 1) % 8;
      check("t2_idx", 32'(gnt_idx), 32'(exp_i));
      check("t2_vld", 32'(gnt_vld), 32'd1);
    end

    // T3: release from owner 5 with 1 and 6 pending
    step(8'h00, 1'b1);
    step(8'h20, 1'b0);
    check("t3_own5", 32'(gnt_idx), 32'd5);
    step(8'h62, 1'b0);
    check("t3_hold5", 32'(gnt), 32'h20);
    step(8'h42, 1'b0);
    check("t3_to6", 32'(gnt_idx), 32'd6);
    step(8'h02, 1'b0);
    check("t3_to1", 32'(gnt_idx), 32'd1);

    // T4: mid-operation reset, then first grant at PTR_INIT
    step(8'h00, 1'b1);
    step(8'h08, 1'b0);
    check("t4_gnt8", 32'(gnt), 32'h08);
    step(8'hFF, 1'b1);
    check("t4_rst_gnt", 32'(gnt), 32'h00);
    check("t4_rst_vld", 32'(gnt_vld), 32'd0);
    check("t4_rst_idx", 32'(gnt_idx), 32'd0);
    step(8'hFF, 1'b0);
    check("t4_ptr_init", 32'(gnt_idx), 32'(PTR_INIT));

    // T5: timeout preemption of owner 3 by client 0
    step(8'h00, 1'b1);
    step(8'h08, 1'b0);
    check("t5_gnt8", 32'(gnt), 32'h08);
    for (int k = 1; k <= 6; k++) begin
      step(8'h09, 1'b0);
      if (TMO_EN && k >= 4) begin
        check("t5_gnt", 32'(gnt), 32'h01);
        check("t5_pre", 32'(preempt), (k == 4) ? 32'd1 : 32'd0);
      end else begin
        check("t5_gnt", 32'(gnt), 32'h08);
        check("t5_pre", 32'(preempt), 32'd0);
      end
    end

    // T6: lone owner is never preempted
    step(8'h00, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step(8'h80, 1'b0);
      check("t6_gnt", 32'(gnt), 32'h80);
      check("t6_pre", 32'(preempt), 32'd0);
    end

    // Random traffic: owners tend to hold; occasional reset
    step(8'h00, 1'b1);
    for (int k = 0; k < 400; k++) begin
      r = 8'($urandom);
      if (m_vld && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
      if ($urandom_range(0, 5) == 0) r = '0;
      step(r, ($urandom_range(0, 49) == 0));
      check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv_vld", 32'(gnt_vld), 32'(gnt != 8'h00));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
